// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types for the four-way round-robin arbiter around the mux4to1B32 datapath.
package mux4_arb_pkg;

    localparam int NREQ = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    function automatic logic [NREQ-1:0] onehot4(input sel_t idx);
        logic [NREQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle for mux4_rr_arbiter; the lock hint exists only when
// BURST_LOCK_EN is defined.
interface mux4_rr_arbiter_if
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]  req;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic [WIDTH-1:0] din3;
`ifdef BURST_LOCK_EN
    logic [NREQ-1:0]  lock;
`endif
    logic [NREQ-1:0]  gnt;
    sel_t             sel;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

`ifdef BURST_LOCK_EN
    modport master (
        input  req, din0, din1, din2, din3, lock, dout_ready,
        output gnt, sel, dout, dout_valid
    );
    modport slave (
        output req, din0, din1, din2, din3, lock, dout_ready,
        input  gnt, sel, dout, dout_valid
    );
`else
    modport master (
        input  req, din0, din1, din2, din3, dout_ready,
        output gnt, sel, dout, dout_valid
    );
    modport slave (
        output req, din0, din1, din2, din3, dout_ready,
        input  gnt, sel, dout, dout_valid
    );
`endif

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick: first set request scanning circularly from last+1.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  sel_t            last_i,
    output sel_t            winner_o,
    output logic            any_o
);
    sel_t              start;
    sel_t              offset;
    logic [2*NREQ-1:0] doubled;
    logic [NREQ-1:0]   rotated;

    // Rotate so the slot after the last winner lands at bit 0, then take the lowest set bit.
    always_comb begin
        start   = last_i + 2'd1;
        doubled = {req_i, req_i} >> start;
        rotated = doubled[NREQ-1:0];
        offset  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = sel_t'(i);
            end
        end
        winner_o = start + offset;
        any_o    = |req_i;
    end
endmodule

// File: rtl/mux4to1B32.sv
// Shared 32-bit four-input word multiplexer; {C1,C0} selects I0..I3.
module mux4to1B32 (
    input  logic        C1,
    input  logic        C0,
    input  logic [31:0] I0,
    input  logic [31:0] I1,
    input  logic [31:0] I2,
    input  logic [31:0] I3,
    output logic [31:0] Y
);
    always_comb begin
        case ({C1, C0})
            2'd0:    Y = I0;
            2'd1:    Y = I1;
            2'd2:    Y = I2;
            default: Y = I3;
        endcase
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of the shared mux4to1B32 with a registered valid/ready output stage.
// Define BURST_LOCK_EN to add the lock hint and bounded burst re-grants.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    mux4_rr_arbiter_if.master bus
);
    arb_state_t       state_q;
    sel_t             last_q;
    sel_t             sel_q;
    sel_t             sel_d;
    sel_t             winner;
    sel_t             pickWinner;
    logic             pickAny;
    logic             capture;
    logic [NREQ-1:0]  gnt_q;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] muxY;
    logic             valid_q;

    if (WIDTH != 32 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_paramCheck
        $error("mux4_rr_arbiter: WIDTH must be 32 and MAX_BURST within 1..15");
    end

    rr_pick4 u_pick (
        .req_i    (bus.req),
        .last_i   (last_q),
        .winner_o (pickWinner),
        .any_o    (pickAny)
    );

`ifdef BURST_LOCK_EN
    logic       lockHeld_q;
    logic [3:0] burstCnt_q;
    logic       stay;

    // A locked owner keeps the bus while it still requests, until it has had MAX_BURST grants in a row.
    always_comb begin
        stay   = lockHeld_q && bus.req[last_q] && (burstCnt_q < 4'(MAX_BURST - 1));
        winner = stay ? last_q : pickWinner;
    end
`else
    assign winner = pickWinner;
`endif

    assign capture = pickAny && ((state_q == IDLE) || bus.dout_ready);
    assign sel_d   = capture ? winner : sel_q;

    mux4to1B32 u_mux (
        .C1 (sel_d[1]),
        .C0 (sel_d[0]),
        .I0 (bus.din0),
        .I1 (bus.din1),
        .I2 (bus.din2),
        .I3 (bus.din3),
        .Y  (muxY)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_q     <= 2'd3;
            sel_q      <= '0;
            gnt_q      <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
`ifdef BURST_LOCK_EN
            lockHeld_q <= 1'b0;
            burstCnt_q <= '0;
`endif
        end else begin
            gnt_q <= '0;
            if (capture) begin
                state_q <= HOLD;
                sel_q   <= winner;
                gnt_q   <= onehot4(winner);
                dout_q  <= muxY;
                valid_q <= 1'b1;
                last_q  <= winner;
`ifdef BURST_LOCK_EN
                lockHeld_q <= bus.lock[winner];
                burstCnt_q <= stay ? burstCnt_q + 4'd1 : 4'd0;
`endif
            end else if (state_q == HOLD && bus.dout_ready) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
`ifdef BURST_LOCK_EN
                lockHeld_q <= 1'b0;
`endif
            end
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.sel        = sel_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a reference model queues per-cycle expected outputs.
module tb_mux4_rr_arbiter;
    import mux4_arb_pkg::*;

    localparam int MAXB = 4;

    typedef struct {
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic [31:0] dout;
        logic        valid;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   testsRun    = 0;
    int   testsFailed = 0;
    exp_t expQ[$];

    logic [1:0]  mLast  = 2'd3;
    logic        mHold  = 1'b0;
    logic [1:0]  mSel   = '0;
    logic [31:0] mDout  = '0;
    logic        mValid = 1'b0;
    logic        mLockQ = 1'b0;
    int          mCnt   = 0;

    mux4_rr_arbiter_if #(.WIDTH(32)) bus ();

    mux4_rr_arbiter #(.WIDTH(32), .MAX_BURST(MAXB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] dinOf(input logic [1:0] idx);
        case (idx)
            2'd0:    return bus.din0;
            2'd1:    return bus.din1;
            2'd2:    return bus.din2;
            default: return bus.din3;
        endcase
    endfunction

    // Reference model: evaluates each rising edge from the driven inputs and queues the expected outputs.
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                expQ.delete();
                mLast = 2'd3; mHold = 1'b0; mSel = '0; mDout = '0; mValid = 1'b0;
                mLockQ = 1'b0; mCnt = 0;
            end else begin
                exp_t       e;
                logic [1:0] w;
                logic       found;
                logic       stay;
                e.gnt = '0;
                if (!mHold || bus.dout_ready) begin
                    if (bus.req != 4'b0000) begin
                        found = 1'b0;
                        w     = '0;
                        for (int k = 1; k <= 4; k++) begin
                            logic [1:0] idx;
                            idx = 2'((int'(mLast) + k) % 4);
                            if (!found && bus.req[idx]) begin
                                w     = idx;
                                found = 1'b1;
                            end
                        end
                        stay = 1'b0;
`ifdef BURST_LOCK_EN
                        stay = mLockQ && bus.req[mLast] && (mCnt + 1 < MAXB);
                        if (stay) w = mLast;
                        mLockQ = bus.lock[w];
`endif
                        mCnt   = stay ? mCnt + 1 : 0;
                        mSel   = w;
                        mDout  = dinOf(w);
                        mValid = 1'b1;
                        mLast  = w;
                        mHold  = 1'b1;
                        e.gnt  = 4'(1) << w;
                    end else if (mHold) begin
                        mValid = 1'b0;
                        mHold  = 1'b0;
                        mLockQ = 1'b0;
                    end
                end
                e.sel   = mSel;
                e.dout  = mDout;
                e.valid = mValid;
                expQ.push_back(e);
            end
        end
    end

    // Monitor: compares DUT outputs on the falling edge, away from the capture edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n || expQ.size() == 0) begin
                checkOutput("rstGnt",   32'(bus.gnt),        32'h0);
                checkOutput("rstSel",   32'(bus.sel),        32'h0);
                checkOutput("rstDout",  bus.dout,            32'h0);
                checkOutput("rstValid", 32'(bus.dout_valid), 32'h0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("gnt",   32'(bus.gnt),        32'(e.gnt));
                checkOutput("sel",   32'(bus.sel),        32'(e.sel));
                checkOutput("dout",  bus.dout,            e.dout);
                checkOutput("valid", 32'(bus.dout_valid), 32'(e.valid));
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] r, input logic rdy, input int n);
        bus.req        = r;
        bus.dout_ready = rdy;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.req        = '0;
        bus.dout_ready = 1'b0;
        bus.din0 = '0; bus.din1 = '0; bus.din2 = '0; bus.din3 = '0;
`ifdef BURST_LOCK_EN
        bus.lock = '0;
`endif
        @(posedge clk);
        #1;
        applyReset();

        // Single request from reset; then the word drains.
        bus.din0 = 32'hDEADBEEF;
        applyStimulus(4'b0001, 1'b1, 1);
        checkOutput("firstDout", bus.dout, 32'hDEADBEEF);
        applyStimulus(4'b0000, 1'b1, 2);

        // Fairness under continuous full load.
        applyReset();
        bus.din0 = 32'h11111111; bus.din1 = 32'h22222222;
        bus.din2 = 32'h33333333; bus.din3 = 32'h44444444;
        applyStimulus(4'b1111, 1'b1, 5);
        applyStimulus(4'b0000, 1'b1, 2);

        // Consumer stall holds the word and suppresses further grants.
        applyStimulus(4'b0100, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 4);
        checkOutput("stallDout", bus.dout, 32'h33333333);
        applyStimulus(4'b0000, 1'b1, 2);

        // Wraparound from the reset pointer.
        applyReset();
        applyStimulus(4'b1001, 1'b1, 1);
        applyStimulus(4'b1000, 1'b1, 1);
        checkOutput("wrapSel", 32'(bus.sel), 32'd3);
        applyStimulus(4'b0000, 1'b1, 2);

        // Asynchronous reset while holding a word.
        applyStimulus(4'b0010, 1'b0, 1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("asyncValid", 32'(bus.dout_valid), 32'h0);
        checkOutput("asyncGnt",   32'(bus.gnt),        32'h0);
        checkOutput("asyncSel",   32'(bus.sel),        32'h0);
        bus.req = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(4'b1111, 1'b1, 2);
        applyStimulus(4'b0000, 1'b1, 2);

`ifdef BURST_LOCK_EN
        applyReset();
        bus.lock = 4'b0001;
        applyStimulus(4'b0011, 1'b1, 8);
        bus.lock = '0;
        applyStimulus(4'b0000, 1'b1, 2);
`endif

        // Random traffic, data and back-pressure.
        for (int i = 0; i < 60; i++) begin
            bus.din0 = $urandom; bus.din1 = $urandom;
            bus.din2 = $urandom; bus.din3 = $urandom;
`ifdef BURST_LOCK_EN
            bus.lock = 4'($urandom_range(0, 15));
`endif
            applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1);
        end
        applyStimulus(4'b0000, 1'b1, 3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin controller that shares one mux4to1B32 datapath among four 32-bit requesters.
- Drives the mux selects (C1/C0) and returns a one-hot capture grant to the winning requester.
- Registers the selected word into an output stage with a valid/ready handshake toward a single consumer.
- Sits between four producer blocks and one shared downstream register/bus.

Parameters:
- WIDTH, 32, data width; must equal the mux4to1B32 width.
- MAX_BURST, 4, maximum consecutive locked grants to one requester; used only with BURST_LOCK_EN; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  4  per-requester request; held with din until gnt.
- din0..din3  input  WIDTH each  requester data words.
- lock  input  4  burst-lock hint; present only with BURST_LOCK_EN.
- gnt  output  4  one-hot, one-cycle capture pulse.
- sel  output  2  mux select; sel[1]=C1, sel[0]=C0.
- dout  output  WIDTH  registered selected word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.

Behaviour:
- Reset (async assert, sync release):
  - gnt=0, sel=0, dout=0, dout_valid=0.
  - State=IDLE.
  - Last-winner pointer=3, so requester 0 wins first.
- Winner: the first set req bit scanning circularly from last+1; the scan wraps 3->0.
- Capture is allowed when state=IDLE, or when state=HOLD and dout_ready=1.
- Capture edge with req!=0, winner w. At that edge:
  - sel<=w; gnt<=onehot(w) for exactly one cycle.
  - dout<=din_w (taken through the shared mux path using the newly chosen select); dout_valid<=1.
  - last<=w; state<=HOLD.
- Latency: req seen at edge N gives dout/dout_valid/gnt visible after edge N, which is one cycle.
- HOLD with dout_ready=0: dout, sel and dout_valid are stable; gnt=0; no new capture.
- HOLD with dout_ready=1 and req=0: dout_valid<=0, state<=IDLE; dout and sel keep their last values.
- HOLD with dout_ready=1 and req!=0: back-to-back capture in the same edge, so dout_valid stays 1 (full throughput).
- Requester deasserts req before gnt: the request is withdrawn and nothing is captured.
- A requester must not reassert req in the cycle gnt is high unless it has a new word.
- Only the current winner is ever affected by a capture; non-winning requests stay pending.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,...
- Reset asserted mid-HOLD: the pending word is dropped and all outputs return to reset values immediately.
- dout_ready while dout_valid=0 is ignored.

Optional Feature:
- Macro: BURST_LOCK_EN.
- With the macro:
  - lock port exists. If lock[w] was 1 at w's capture and req[w] is still 1 at the next capture opportunity, w wins again, overriding rotation.
  - A 4-bit burst counter increments per locked re-grant. At MAX_BURST consecutive grants to w, normal rotation is forced and the counter clears.
  - The counter also clears on any grant to a different requester and on reset.
- Without the macro: no lock port, no counter, pure round-robin.

Decomposition:
- Package mux4_arb_pkg holds:
  - typedef enum {IDLE, HOLD} arb_state_t;
  - localparam NREQ=4;
  - typedef logic [1:0] sel_t.
- One sub-module: rr_pick4, purely combinational. Inputs req[3:0] and last[1:0]; outputs winner[1:0] and any.
- The datapath itself is an instance of the existing mux4to1B32, driven by sel.

Test Plan:
- Reset, then req=0001, din0=0xDEADBEEF, dout_ready=1 -> next cycle gnt=0001, sel=0, dout=0xDEADBEEF, dout_valid=1; following cycle dout_valid=0.
- req=1111 held, din_i=0x1111_1111*(i+1), dout_ready=1 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; dout 0x11111111,0x22222222,0x33333333,0x44444444.
- req=0100, dout_ready=0 for 5 cycles -> dout=din2 and sel=2 stable, gnt pulses once only; dout_ready=1 -> dout_valid drops next edge.
- last=3 (after reset), req=1001 -> requester 0 wins, then requester 3 (wraparound check).
- Reset_n pulsed low mid-HOLD with dout_valid=1 -> dout_valid=0, gnt=0, sel=0 asynchronously; next grant starts from requester 0.
- BURST_LOCK_EN, MAX_BURST=4, req=0011, lock=0001 -> grants 0,0,0,0,1,0,...
